// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction-memory port, redirect request and decode-side handshake.
// master = fetch_queue_unit, slave = imem/decode environment.
interface fetch_queue_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  br_taken,
        input  br_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output br_taken,
        output br_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC/nPC pair, async imem fetch, DEPTH-entry {pc, instr} queue.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
module fetch_queue_unit #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [DATA_W-1:0]    RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    fetch_queue_unit_if.master           bus,
`ifdef FETCH_PERF_CNT_EN
    output logic [DATA_W-1:0]            fetch_cnt,
    output logic [DATA_W-1:0]            flush_cnt,
`endif
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] npc_q;
    logic [DATA_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              out_valid;
    logic              pop;
    logic              fetch;

    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid & bus.out_ready & ~bus.br_taken;
        // A pop frees a slot in the same cycle, so a full queue still accepts a fetch.
        fetch     = ~bus.br_taken & ((count_q < CNT_W'(DEPTH)) | pop);
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign count         = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            npc_q    <= RESET_PC + DATA_W'(4);
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (bus.br_taken) begin
            pc_q     <= bus.br_target;
            npc_q    <= bus.br_target + DATA_W'(4);
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fetch) begin
                pc_mem_q[wr_ptr_q]    <= pc_q;
                instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                pc_q                  <= npc_q;
                npc_q                 <= npc_q + DATA_W'(4);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (fetch && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!fetch && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [DATA_W-1:0] fetch_cnt_q;
    logic [DATA_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch) begin
                fetch_cnt_q <= fetch_cnt_q + DATA_W'(1);
            end
            // Counts the entries discarded by the redirect.
            if (bus.br_taken) begin
                flush_cnt_q <= flush_cnt_q + DATA_W'(count_q);
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
